// File: rtl/dsp_fe_lut_pkg.sv
// dsp_fe_lut_pkg: shared state/opcode types and table slice addressing for the lane LUT loader.
package dsp_fe_lut_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_MISSION, ST_SEED, ST_LOAD, ST_DRAIN} lut_ldr_state_e;
  typedef enum logic [1:0] {OP_IDLE = 2'd0, OP_SEED = 2'd1, OP_COMMIT = 2'd2, OP_MISSION = 2'd3} lut_ldr_op_e;
  // Entry 0 lands in the MSB slice so the bus matches streaming-pack order.
  function automatic int unsigned tbl_off(input int unsigned a, input int unsigned aw, input int unsigned dw);
    return ((32'd1 << aw) - 32'd1 - a) * dw;
  endfunction
endpackage

// File: rtl/dsp_fe_lut_shadow.sv
// dsp_fe_lut_shadow: shadow LUT entries, written bitmap with clear, and flattened table bus.
module dsp_fe_lut_shadow
  import dsp_fe_lut_pkg::*;
#(
  parameter int AW = 6,
  parameter int DW = 6
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_addr,
  input  logic [DW-1:0]         i_data,
  input  logic                  i_clr,
  output logic [(2**AW)*DW-1:0] o_table,
  output logic                  o_all_written
);
  localparam int N = 2**AW;
  logic [DW-1:0] mem [N];
  logic [N-1:0]  wmap;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int a = 0; a < N; a++) mem[a] <= '0;
      wmap <= '0;
    end else begin
      if (i_we) mem[i_addr] <= i_data;
      if (i_clr) wmap <= '0;
      else if (i_we) wmap[i_addr] <= 1'b1;
    end
  end
  for (genvar g = 0; g < N; g++) begin : g_flat
    assign o_table[tbl_off(g, AW, DW) +: DW] = mem[g];
  end
  assign o_all_written = &wmap;
endmodule

// File: rtl/dsp_fe_lane_lut_loader.sv
// dsp_fe_lane_lut_loader: sequences shadow-table writes and LUT mode strobes, holding each strobe
// until the LUT captures on i_en and draining the LUT pipeline before mission mode resumes.
module dsp_fe_lane_lut_loader
  import dsp_fe_lut_pkg::*;
#(
  parameter int INPUT_WIDTH    = 6,
  parameter int OUTPUT_WIDTH   = 6,
  parameter int PIPELINE_DEPTH = 2,
  parameter int REQUIRE_FULL   = 1
) (
  input  logic                                      i_clk,
  input  logic                                      i_rst,
  input  logic                                      i_en,
  input  logic                                      i_wr_valid,
  output logic                                      o_wr_ready,
  input  logic [INPUT_WIDTH-1:0]                    i_wr_addr,
  input  logic [OUTPUT_WIDTH-1:0]                   i_wr_data,
  input  logic                                      i_cmd_valid,
  output logic                                      o_cmd_ready,
  input  logic [1:0]                                i_cmd_op,
  output logic                                      o_cmd_err,
  output logic                                      o_busy,
  output logic                                      o_all_written,
  output logic [(2**INPUT_WIDTH)*OUTPUT_WIDTH-1:0]  o_cfg_table,
  output logic                                      o_cfg_mode_load,
  output logic                                      o_cfg_mode_seed,
  output logic                                      o_cfg_mode_mission
);
  localparam int CW = $clog2(PIPELINE_DEPTH + 1);
  lut_ldr_state_e state, state_n, ret, ret_n;
  lut_ldr_op_e    op;
  logic [CW-1:0]  cnt, cnt_n;
  logic           err_n, wr_acc, cmd_acc, clr;
  assign op          = lut_ldr_op_e'(i_cmd_op);
  assign o_wr_ready  = state != ST_LOAD;
  assign o_cmd_ready = state == ST_IDLE || state == ST_MISSION;
  assign o_busy      = state == ST_SEED || state == ST_LOAD || state == ST_DRAIN;
  assign wr_acc      = i_wr_valid & o_wr_ready;
  assign cmd_acc     = i_cmd_valid & o_cmd_ready;
  assign clr         = state == ST_LOAD && i_en;
  dsp_fe_lut_shadow #(.AW(INPUT_WIDTH), .DW(OUTPUT_WIDTH)) u_shadow (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_we          (wr_acc),
    .i_addr        (i_wr_addr),
    .i_data        (i_wr_data),
    .i_clr         (clr),
    .o_table       (o_cfg_table),
    .o_all_written (o_all_written)
  );
  always_comb begin
    state_n = state;
    ret_n   = ret;
    cnt_n   = cnt;
    err_n   = 1'b0;
    case (state)
      ST_IDLE, ST_MISSION:
        if (cmd_acc)
          case (op)
            OP_IDLE:    state_n = ST_IDLE;
            OP_MISSION: state_n = ST_MISSION;
            OP_SEED: begin
              ret_n   = state;
              state_n = ST_SEED;
            end
            default:
              if (REQUIRE_FULL != 0 && !o_all_written) err_n = 1'b1;
              else begin
                ret_n   = state;
                state_n = ST_LOAD;
              end
          endcase
      ST_SEED, ST_LOAD:
        if (i_en) state_n = ret == ST_MISSION ? ST_DRAIN : ST_IDLE;
      ST_DRAIN:
        if (i_en) begin
          cnt_n   = cnt == CW'(PIPELINE_DEPTH - 1) ? '0 : cnt + 1'b1;
          state_n = cnt == CW'(PIPELINE_DEPTH - 1) ? ST_MISSION : ST_DRAIN;
        end
      default: state_n = ST_IDLE;
    endcase
  end
  // Mode strobes are flopped from the next state so the LUT never sees a combinational path.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state              <= ST_IDLE;
      ret                <= ST_IDLE;
      cnt                <= '0;
      o_cmd_err          <= 1'b0;
      o_cfg_mode_load    <= 1'b0;
      o_cfg_mode_seed    <= 1'b0;
      o_cfg_mode_mission <= 1'b0;
    end else begin
      state              <= state_n;
      ret                <= ret_n;
      cnt                <= cnt_n;
      o_cmd_err          <= err_n;
      o_cfg_mode_load    <= state_n == ST_LOAD;
      o_cfg_mode_seed    <= state_n == ST_SEED;
      o_cfg_mode_mission <= state_n == ST_MISSION;
    end
  end
endmodule

// File: tb/tb_dsp_fe_lane_lut_loader.sv
// tb_dsp_fe_lane_lut_loader: randomized self-checking bench against a behavioural table/mode model.
module tb_dsp_fe_lane_lut_loader;
  logic         i_clk, i_rst, i_en;
  logic         i_wr_valid, o_wr_ready;
  logic [5:0]   i_wr_addr, i_wr_data;
  logic         i_cmd_valid, o_cmd_ready;
  logic [1:0]   i_cmd_op;
  logic         o_cmd_err, o_busy, o_all_written;
  logic [383:0] o_cfg_table;
  logic         o_cfg_mode_load, o_cfg_mode_seed, o_cfg_mode_mission;
  int checks = 0, errors = 0;
  logic [5:0] mdl [64];
  bit         wmap [64];
  dsp_fe_lane_lut_loader #(
    .INPUT_WIDTH(6), .OUTPUT_WIDTH(6), .PIPELINE_DEPTH(2), .REQUIRE_FULL(1)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en),
    .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_op(i_cmd_op),
    .o_cmd_err(o_cmd_err), .o_busy(o_busy), .o_all_written(o_all_written), .o_cfg_table(o_cfg_table),
    .o_cfg_mode_load(o_cfg_mode_load), .o_cfg_mode_seed(o_cfg_mode_seed), .o_cfg_mode_mission(o_cfg_mode_mission)
  );
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  task automatic chk(input string tag, input logic [383:0] got, input logic [383:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [383:0] packed_tbl();
    logic [383:0] p = '0;
    for (int a = 0; a < 64; a++) p[(63 - a) * 6 +: 6] = mdl[a];
    return p;
  endfunction
  function automatic bit mdl_full();
    for (int a = 0; a < 64; a++) if (!wmap[a]) return 1'b0;
    return 1'b1;
  endfunction
  task automatic mdl_reset();
    for (int a = 0; a < 64; a++) begin mdl[a] = '0; wmap[a] = 1'b0; end
  endtask
  task automatic mdl_commit();
    for (int a = 0; a < 64; a++) wmap[a] = 1'b0;
  endtask
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask
  task automatic wr(input logic [5:0] a, input logic [5:0] d);
    i_wr_valid = 1'b1; i_wr_addr = a; i_wr_data = d;
    mdl[a] = d; wmap[a] = 1'b1;
    step();
    i_wr_valid = 1'b0;
  endtask
  task automatic cmd(input logic [1:0] op);
    i_cmd_valid = 1'b1; i_cmd_op = op;
    step();
    i_cmd_valid = 1'b0;
  endtask
  task automatic fill_random();
    for (int a = 0; a < 64; a++) begin
      i_en = 1'($urandom);
      wr(6'(a), 6'($urandom));
    end
  endtask
  task automatic chk_modes(input string tag, input logic [2:0] exp);
    chk(tag, {o_cfg_mode_load, o_cfg_mode_seed, o_cfg_mode_mission}, exp);
  endtask
  initial begin
    int n, k, perm[64];
    logic [5:0] a;
    i_rst = 1'b1; i_en = 1'b0; i_wr_valid = 1'b0; i_wr_addr = '0; i_wr_data = '0;
    i_cmd_valid = 1'b0; i_cmd_op = '0;
    mdl_reset();
    step(); step();
    i_rst = 1'b0;
    step();
    chk("rst_modes", {o_cfg_mode_load, o_cfg_mode_seed, o_cfg_mode_mission}, 3'b000);
    chk("rst_ready", {o_wr_ready, o_cmd_ready}, 2'b11);
    chk("rst_flags", {o_cmd_err, o_busy, o_all_written}, 3'b000);
    chk("rst_table", o_cfg_table, '0);
    // full table a = 63-a written in random order, then commit with i_en high
    for (int i = 0; i < 64; i++) perm[i] = i;
    for (int i = 63; i > 0; i--) begin k = $urandom_range(i, 0); n = perm[i]; perm[i] = perm[k]; perm[k] = n; end
    for (int i = 0; i < 64; i++) begin
      i_en = 1'($urandom);
      wr(6'(perm[i]), 6'(63 - perm[i]));
      chk("fill_allw", o_all_written, mdl_full());
    end
    chk("fill_table", o_cfg_table, packed_tbl());
    chk("top_slice", o_cfg_table[383:378], 6'd63);
    chk("bot_slice", o_cfg_table[5:0], 6'd0);
    i_en = 1'b1;
    cmd(2'd2);
    chk("load_ready", {o_wr_ready, o_cmd_ready, o_busy}, 3'b001);
    n = 0;
    while (o_cfg_mode_load && n < 10) begin n++; step(); end
    mdl_commit();
    chk("load_cycles", n, 1);
    chk("post_load_allw", o_all_written, mdl_full());
    chk_modes("post_load_idle", 3'b000);
    chk("post_load_table", o_cfg_table, packed_tbl());
    // partial table: commit must be rejected with a single err pulse
    for (int i = 0; i < 10; i++) begin
      do a = 6'($urandom); while (wmap[a]);
      wr(a, 6'($urandom));
    end
    chk("part_allw", o_all_written, 1'b0);
    cmd(2'd2);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      n += int'(o_cmd_err);
      chk_modes("rej_modes", 3'b000);
      chk("rej_ready", o_cmd_ready, 1'b1);
      step();
    end
    chk("rej_err_cycles", n, 1);
    // mission, then seed with i_en low 5 cycles
    cmd(2'd3);
    chk_modes("mission_on", 3'b001);
    i_en = 1'b0;
    cmd(2'd1);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      i_en = (i == 5);
      if (o_cfg_mode_seed && !o_cfg_mode_mission) n++;
      step();
    end
    chk("seed_cycles", n, 6);
    chk_modes("drain_modes", 3'b000);
    chk("drain_busy", o_busy, 1'b1);
    n = 0; k = 0;
    while (!o_cfg_mode_mission && k < 40) begin
      i_en = 1'($urandom);
      if (i_en) n++;
      step(); k++;
    end
    chk("drain_en_cycles", n, 2);
    chk_modes("mission_back", 3'b001);
    chk("seed_table", o_cfg_table, packed_tbl());
    // write coincident with commit accept from mission
    fill_random();
    i_en = 1'b0;
    i_wr_valid = 1'b1; i_wr_addr = 6'd5; i_wr_data = 6'h2A;
    i_cmd_valid = 1'b1; i_cmd_op = 2'd2;
    mdl[5] = 6'h2A; wmap[5] = 1'b1;
    step();
    i_cmd_valid = 1'b0;
    i_wr_addr = 6'd7; i_wr_data = ~mdl[7];
    k = $urandom_range(4, 1);
    for (int i = 0; i < k; i++) begin
      chk_modes("load_held", 3'b100);
      chk("load_stall", {o_wr_ready, o_cmd_ready}, 2'b00);
      step();
    end
    i_wr_valid = 1'b0; i_en = 1'b1;
    step();
    mdl_commit();
    chk_modes("load2_exit", 3'b000);
    chk("load2_slice5", o_cfg_table[(63 - 5) * 6 +: 6], 6'h2A);
    chk("load2_table", o_cfg_table, packed_tbl());
    step(); step();
    chk_modes("load2_mission", 3'b001);
    // random idle traffic: writes ignore i_en
    cmd(2'd0);
    for (int i = 0; i < 150; i++) begin
      i_en = 1'($urandom);
      if ($urandom_range(3, 0) != 0) wr(6'($urandom), 6'($urandom)); else step();
      chk("rand_table", o_cfg_table, packed_tbl());
      chk("rand_allw", o_all_written, mdl_full());
    end
    // async reset in the middle of a load
    fill_random();
    i_en = 1'b0;
    cmd(2'd2);
    chk_modes("pre_rst_load", 3'b100);
    #2 i_rst = 1'b1;
    #1;
    mdl_reset();
    chk_modes("midrst_modes", 3'b000);
    chk("midrst_table", o_cfg_table, packed_tbl());
    chk("midrst_ready", {o_wr_ready, o_cmd_ready, o_busy, o_all_written}, 4'b1100);
    #2 i_rst = 1'b0;
    step();
    chk_modes("postrst_modes", 3'b000);
    chk("postrst_ready", {o_wr_ready, o_cmd_ready}, 2'b11);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
